// File: rtl/o_bram_writer.sv
// Result-row writer: buffers systolic-array rows in a 2-entry FIFO, streams the first
// N lanes of each row into O_BRAM, then posts a done flag to SP_BRAM.
// Optional build macro: OUTPUT_RELU_EN (clamps negative lanes to zero before writing).
//
//  state | meaning
//  IDLE  | waiting for cfg_valid; M/N latched and clamped on acceptance
//  RUN   | accepting rows and writing one O_BRAM word per cycle while the FIFO holds data
//  DONE  | one-cycle done-flag write to SP_BRAM, then back to IDLE
module o_bram_writer #(
  parameter int SYS_ARR_SIZE = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int DONE_ADDR    = 100
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 cfg_valid,
  input  logic [31:0]                          cfg_m,
  input  logic [31:0]                          cfg_n,
  input  logic                                 row_valid,
  output logic                                 row_ready,
  input  logic [SYS_ARR_SIZE*PE_OUT_WIDTH-1:0] row_data,
  output logic [31:0]                          addr_o_bram,
  output logic                                 enable_o_bram,
  output logic [3:0]                           w_enable_o_bram,
  output logic [31:0]                          data_in_o_bram,
  output logic                                 sp_wr_en,
  output logic [31:0]                          sp_wr_addr,
  output logic [31:0]                          sp_wr_data,
  output logic                                 busy
);

  localparam int RW = SYS_ARR_SIZE * PE_OUT_WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d, n_q, n_d;
  logic [31:0] rows_acc_q, rows_acc_d;
  logic [31:0] rows_wr_q, rows_wr_d;
  logic [31:0] col_q, col_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        wr_ptr_q, rd_ptr_q;
  logic [RW-1:0] fifo_q [2];

  logic [31:0] cfg_m_cl, cfg_n_cl;
  logic        ready_int, push, pop, wr_valid;
  logic [RW-1:0] head;
  logic [PE_OUT_WIDTH-1:0] lane_raw, lane_out;

  assign cfg_m_cl  = (cfg_m > 32'(SYS_ARR_SIZE)) ? 32'(SYS_ARR_SIZE) : cfg_m;
  assign cfg_n_cl  = (cfg_n > 32'(SYS_ARR_SIZE)) ? 32'(SYS_ARR_SIZE) : cfg_n;
  assign ready_int = (state_q == RUN) && (cnt_q != 2'd2) && (rows_acc_q < m_q);
  assign push      = row_valid && ready_int;
  assign wr_valid  = (state_q == RUN) && (cnt_q != 2'd0);
  assign head      = fifo_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    n_d        = n_q;
    rows_acc_d = rows_acc_q;
    rows_wr_d  = rows_wr_q;
    col_d      = col_q;
    word_d     = word_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          m_d        = cfg_m_cl;
          n_d        = cfg_n_cl;
          rows_acc_d = '0;
          rows_wr_d  = '0;
          col_d      = '0;
          word_d     = '0;
          state_d    = (cfg_m_cl == 32'd0 || cfg_n_cl == 32'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) rows_acc_d = rows_acc_q + 32'd1;
        if (wr_valid) begin
          word_d = word_q + 32'd1;
          if (col_q == n_q - 32'd1) begin
            pop       = 1'b1;
            col_d     = '0;
            rows_wr_d = rows_wr_q + 32'd1;
            if (rows_wr_q + 32'd1 == m_q) state_d = DONE;
          end else begin
            col_d = col_q + 32'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      m_q        <= '0;
      n_q        <= '0;
      rows_acc_q <= '0;
      rows_wr_q  <= '0;
      col_q      <= '0;
      word_q     <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      rows_acc_q <= rows_acc_d;
      rows_wr_q  <= rows_wr_d;
      col_q      <= col_d;
      word_q     <= word_d;
      cnt_q      <= cnt_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: an empty FIFO is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= row_data;
  end

  always_comb begin
    lane_raw = '0;
    for (int j = 0; j < SYS_ARR_SIZE; j++) begin
      if (col_q == 32'(j)) lane_raw = head[j*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
`ifdef OUTPUT_RELU_EN
    lane_out = lane_raw[PE_OUT_WIDTH-1] ? '0 : lane_raw;
`else
    lane_out = lane_raw;
`endif
  end

  // Outputs are gated by reset so they read zero for as long as reset is held low.
  assign row_ready       = reset && ready_int;
  assign enable_o_bram   = reset && wr_valid;
  assign w_enable_o_bram = {4{enable_o_bram}};
  assign addr_o_bram     = enable_o_bram ? (word_q << 2) : '0;
  assign data_in_o_bram  = enable_o_bram ? 32'(lane_out) : '0;
  assign sp_wr_en        = reset && (state_q == DONE);
  assign sp_wr_addr      = sp_wr_en ? 32'(DONE_ADDR) : '0;
  assign sp_wr_data      = sp_wr_en ? 32'd1 : '0;
  assign busy            = reset && (state_q != IDLE);

endmodule
